// File: rtl/fma_norm_pkg.sv
// FMA normalisation shift finder: shared types.
// Search modes, the stage-1 payload and segment sizing.
package fma_norm_pkg;

  typedef enum logic [1:0] {
    FNS_FULL   = 2'd0,
    FNS_WINDOW = 2'd1,
    FNS_TOP    = 2'd2
  } fns_mode_t;

  function automatic int nseg(input int w, input int seg);
    return (w + seg - 1) / seg;
  endfunction

  localparam int FNS_W     = 71;
  localparam int FNS_SEG   = 8;
  localparam int FNS_TAG_W = 4;
  localparam int FNS_NSEG  = nseg(FNS_W, FNS_SEG);
  localparam int FNS_IW    = $clog2(FNS_SEG);

  typedef struct packed {
    logic [FNS_NSEG-1:0]             nz;
    logic [FNS_NSEG-1:0][FNS_IW-1:0] idx;
    logic                            zero;
    fns_mode_t                       mode;
    logic [FNS_TAG_W-1:0]            tag;
  } fns_s1_t;

endpackage

// File: rtl/fma_norm_shift_pipe_seg_lzd.sv
// Leading-one detector for one segment.
// Highest set bit wins; idx is 0 when the segment is empty.
module fma_seg_lzd #(
  parameter int SEG = 8,
  parameter int IW  = (SEG > 1) ? $clog2(SEG) : 1
) (
  input  logic [SEG-1:0] d_i,
  output logic           nz_o,
  output logic [IW-1:0]  idx_o
);

  // scan upward so the highest one overwrites lower ones
  always_comb begin
    nz_o  = 1'b0;
    idx_o = '0;
    for (int i = 0; i < SEG; i++) begin
      if (d_i[i]) begin
        nz_o  = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/fma_norm_shift_pipe.sv
// Two-stage leading-one finder for FMA normalisation.
// Stage 1: mask + segment LZDs; stage 2: combine into shift.
module fma_norm_shift_pipe
  import fma_norm_pkg::*;
#(
  parameter int W         = FNS_W,
  parameter int POINT_POS = 32,
  parameter int WIN       = 3,
  parameter int SEG       = FNS_SEG,
  parameter int ACNT_W    = 7,
  parameter int SHIFT_W   = 8,
  parameter int TAG_W     = FNS_TAG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       sm,
  input  logic [ACNT_W-1:0]  a_cnt,
  input  logic [1:0]         mode,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SHIFT_W-1:0] m_shift,
  output logic               one_less,
  output logic               zero,
  output logic               miss,
  output logic [TAG_W-1:0]   tag_out
);

  localparam int NSEG = nseg(W, SEG);
  localparam int IW   = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int LO   = W - 1 - POINT_POS;
  localparam int MAXD = (POINT_POS > LO) ? POINT_POS : LO;

  if (!((1 << (SHIFT_W - 1)) > MAXD)) begin : g_bad_shift_w
    $error("SHIFT_W cannot hold the largest shift");
  end
  if (NSEG > FNS_NSEG || IW > FNS_IW || TAG_W > FNS_TAG_W)
  begin : g_bad_payload
    $error("stage-1 payload too narrow for parameters");
  end

  logic adv1, adv2;
  logic s1_valid_q, s2_valid_q;
  fns_s1_t s1_d, s1_q;
  fns_mode_t mode_n;

  logic [W-1:0]        mask;
  logic [W-1:0]        msm;
  logic [NSEG*SEG-1:0] msm_pad;
  logic [NSEG-1:0]     seg_nz;
  logic [IW-1:0]       seg_idx [NSEG];

  assign adv2      = ~s2_valid_q | out_ready;
  assign adv1      = ~s1_valid_q | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;

  // encoding 3 folds into FULL
  always_comb begin
    mode_n = FNS_FULL;
    unique case (1'b1)
      (mode == 2'd1): mode_n = FNS_WINDOW;
      (mode == 2'd2): mode_n = FNS_TOP;
      default:        mode_n = FNS_FULL;
    endcase
  end

  // search-range mask; window bits off either end drop out
  always_comb begin
    int top;
    top  = POINT_POS + 1 - int'($signed(a_cnt));
    mask = '0;
    for (int i = 0; i < W; i++) begin
      unique case (mode_n)
        FNS_WINDOW:
          mask[i] = (i <= top) && (i >= top - WIN + 1);
        FNS_TOP:
          mask[i] = (i <= POINT_POS + 2) && (i >= POINT_POS - 1);
        default:
          mask[i] = 1'b1;
      endcase
    end
  end

  assign msm     = sm & mask;
  assign msm_pad = (NSEG*SEG)'(msm);

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    fma_seg_lzd #(.SEG(SEG), .IW(IW)) u_lzd (
      .d_i   (msm_pad[g*SEG +: SEG]),
      .nz_o  (seg_nz[g]),
      .idx_o (seg_idx[g])
    );
  end

  // pack the partial encodings for stage 2
  always_comb begin
    s1_d      = '0;
    s1_d.zero = (sm == '0);
    s1_d.mode = mode_n;
    s1_d.tag[TAG_W-1:0] = tag_in;
    for (int s = 0; s < NSEG; s++) begin
      s1_d.nz[s]          = seg_nz[s];
      s1_d.idx[s][IW-1:0] = seg_idx[s];
    end
  end

  logic [SHIFT_W-1:0] shift_d;
  logic               one_less_d, miss_d;

  // highest nonzero segment gives the global index
  always_comb begin
    int   lz;
    int   diff;
    logic found;
    found      = 1'b0;
    lz         = 0;
    shift_d    = '0;
    one_less_d = 1'b0;
    miss_d     = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      if (s1_q.nz[s]) begin
        found = 1'b1;
        lz    = s * SEG + int'(s1_q.idx[s][IW-1:0]);
      end
    end
    diff = POINT_POS - lz;
    if (s1_q.zero) begin
      miss_d = 1'b0;
    end else if (!found) begin
      miss_d = 1'b1;
    end else begin
      shift_d    = diff[SHIFT_W-1:0];
      one_less_d = (s1_q.mode == FNS_TOP) &&
                   (lz == POINT_POS - 1);
    end
  end

  // stage 1 registers: load on accept, advance with adv1
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // stage 2 registers: outputs hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      m_shift    <= '0;
      one_less   <= 1'b0;
      zero       <= 1'b0;
      miss       <= 1'b0;
      tag_out    <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        m_shift  <= shift_d;
        one_less <= one_less_d;
        zero     <= s1_q.zero;
        miss     <= miss_d;
        tag_out  <= s1_q.tag[TAG_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fma_norm_shift_pipe.sv
// Bench for fma_norm_shift_pipe: vector table plus
// backpressure and mid-flight reset sequences.
module tb_fma_norm_shift_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [70:0] sm;
  logic [6:0]  a_cnt;
  logic [1:0]  mode;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  m_shift;
  logic        one_less, zero, miss;
  logic [3:0]  tag_out;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fma_norm_shift_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sm        (sm),
    .a_cnt     (a_cnt),
    .mode      (mode),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m_shift   (m_shift),
    .one_less  (one_less),
    .zero      (zero),
    .miss      (miss),
    .tag_out   (tag_out)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [6:0]  a_cnt;
    logic [70:0] sm;
    logic [3:0]  tag;
    logic [7:0]  shift;
    logic        ol;
    logic        z;
    logic        ms;
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] m, input int a,
    input int b0, input int b1, input int tg,
    input int sh, input bit ol, input bit z, input bit ms
  );
    vec_t v;
    logic [70:0] one;
    one     = 71'd1;
    v.mode  = m;
    v.a_cnt = 7'(a);
    v.sm    = '0;
    if (b0 >= 0) v.sm = v.sm | (one << b0);
    if (b1 >= 0) v.sm = v.sm | (one << b1);
    v.tag   = 4'(tg);
    v.shift = 8'(sh);
    v.ol    = ol;
    v.z     = z;
    v.ms    = ms;
    return v;
  endfunction

  task automatic chk(input string n,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", n, got, exp);
    end
  endtask

  task automatic send(input vec_t v);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    sm       = v.sm;
    a_cnt    = v.a_cnt;
    mode     = v.mode;
    tag_in   = v.tag;
    n = 0;
    #2;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_out(input string n, input vec_t v);
    chk({n, ".valid"}, 64'(out_valid), 64'd1);
    chk({n, ".shift"}, 64'(m_shift), 64'(v.shift));
    chk({n, ".one_less"}, 64'(one_less), 64'(v.ol));
    chk({n, ".zero"}, 64'(zero), 64'(v.z));
    chk({n, ".miss"}, 64'(miss), 64'(v.ms));
    chk({n, ".tag"}, 64'(tag_out), 64'(v.tag));
  endtask

  // waits for out_valid; returns negedges counted since accept
  task automatic wait_out(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 30);
    if (!out_valid) chk("out_timeout", 64'd0, 64'd1);
  endtask

  vec_t tbl [16];
  vec_t bp  [4];

  initial begin
    int lat;
    bit bad;
    vec_t f;
    logic [7:0] s0;
    logic [3:0] t0;

    tbl[0]  = mk(2'd0,   0, 34, -1,  0,  -2, 0, 0, 0);
    tbl[1]  = mk(2'd2,   0, 31,  5,  1,   1, 1, 0, 0);
    tbl[2]  = mk(2'd2,   0, 20, -1,  2,   0, 0, 0, 1);
    tbl[3]  = mk(2'd1,  -5, 37, 60,  3,  -5, 0, 0, 0);
    tbl[4]  = mk(2'd1,  -5, 10, -1,  4,   0, 0, 0, 1);
    tbl[5]  = mk(2'd0,   0, -1, -1,  5,   0, 0, 1, 0);
    tbl[6]  = mk(2'd0,   0,  0, -1,  6,  32, 0, 0, 0);
    tbl[7]  = mk(2'd0,   0, 70, -1,  7, -38, 0, 0, 0);
    tbl[8]  = mk(2'd3,   0, 34, -1,  8,  -2, 0, 0, 0);
    tbl[9]  = mk(2'd2,   0, 34, -1,  9,  -2, 0, 0, 0);
    tbl[10] = mk(2'd2,   0, 35, -1, 10,   0, 0, 0, 1);
    tbl[11] = mk(2'd1,  35, 35, -1, 11,   0, 0, 0, 1);
    tbl[12] = mk(2'd1, -37, 69, -1, 12, -37, 0, 0, 0);
    tbl[13] = mk(2'd1, -40, 69, -1, 13,   0, 0, 0, 1);
    tbl[14] = mk(2'd1,   0, 33, 31, 14,  -1, 0, 0, 0);
    tbl[15] = mk(2'd2,   0, 32, 31, 15,   0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      bp[i] = mk(2'd0, 0, 31 + i, -1, i + 1, 1 - i, 0, 0, 0);

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sm        = '0;
    a_cnt     = '0;
    mode      = '0;
    tag_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.outputs",
        64'({m_shift, one_less, zero, miss, tag_out}), 64'd0);
    reset = 1'b0;

    // directed vectors, one at a time, unstalled
    for (int i = 0; i < 16; i++) begin
      send(tbl[i]);
      wait_out(lat);
      chk($sformatf("v%0d.latency", i), 64'(lat), 64'd2);
      check_out($sformatf("v%0d", i), tbl[i]);
    end
    @(negedge clk);

    // backpressure: 4 beats into a stalled pipe
    out_ready = 1'b0;
    fork
      begin
        send(bp[0]);
        send(bp[1]);
        @(negedge clk);
        #2 chk("bp.in_ready_low", 64'(in_ready), 64'd0);
        send(bp[2]);
        send(bp[3]);
      end
      begin
        wait_out(lat);
        s0  = m_shift;
        t0  = tag_out;
        bad = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!out_valid || m_shift !== s0 || tag_out !== t0)
            bad = 1'b1;
        end
        chk("bp.hold_stable", 64'(bad), 64'd0);
        chk("bp.held_tag", 64'(t0), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          #1 check_out($sformatf("bp%0d", k + 1), bp[k]);
          @(negedge clk);
        end
      end
    join
    repeat (2) @(negedge clk);

    // reset with two beats in flight
    out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[3]);
    @(negedge clk);
    chk("rip.pre_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rip.out_valid", 64'(out_valid), 64'd0);
    chk("rip.in_ready", 64'(in_ready), 64'd1);
    chk("rip.outputs",
        64'({m_shift, one_less, zero, miss, tag_out}), 64'd0);
    out_ready = 1'b1;
    f = mk(2'd0, 0, 36, -1, 9, -4, 0, 0, 0);
    send(f);
    @(negedge clk);
    chk("rip.mid_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_out("rip.fresh", f);
    @(negedge clk);
    chk("rip.no_ghost", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
